// File: rtl/clock_set_controller_if.sv
// Button, timekeeper and preset-load signals between the clock front-end and its surroundings.
// The controller connects through the slave modport; the surrounding logic connects through master.
interface clock_set_controller_if;
  logic       center;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic [4:0] cur_hrs;
  logic [5:0] cur_min;
  logic       load;
  logic [4:0] load_hrs;
  logic [5:0] load_min;
  logic       run_en;
  logic       edit_field;
  logic       clock_mode_led;
  logic       pm_led;

  modport master (
    output center, left, right, up, down, cur_hrs, cur_min,
    input  load, load_hrs, load_min, run_en, edit_field, clock_mode_led, pm_led
  );

  modport slave (
    input  center, left, right, up, down, cur_hrs, cur_min,
    output load, load_hrs, load_min, run_en, edit_field, clock_mode_led, pm_led
  );
endinterface

// File: rtl/clock_set_controller.sv
// Digital clock front-end: button debounce, press/auto-repeat events and the run/set mode FSM.
// Edit registers hold the time in 24-hour form and are loaded into the timekeeper on commit.
module clock_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
  input logic                   clk,
  input logic                   reset,
  clock_set_controller_if.slave bus
);

  localparam int unsigned NB   = 5;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_W = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned B_DN = 0;
  localparam int unsigned B_UP = 1;
  localparam int unsigned B_RT = 2;
  localparam int unsigned B_LT = 3;
  localparam int unsigned B_CT = 4;

  typedef enum logic [1:0] {RUN, SET_MIN, SET_HR, COMMIT} state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] db;
  logic [NB-1:0] db_prev;
  logic [NB-1:0] pls;
  logic [1:0]    rep_hit;
  logic          ev_center, ev_swap, ev_up, ev_dn;

  assign raw = {bus.center, bus.left, bus.right, bus.up, bus.down};

  // Per-button synchronizer and debounce counter
  for (genvar i = 0; i < NB; i++) begin : g_btn
    logic            sync1, sync2, level;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        level <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
    end

    assign db[i] = level;
  end

  // Auto-repeat for down (0) and up (1); counter value equals cycles since the press edge
  for (genvar j = 0; j < 2; j++) begin : g_rep
    logic [RP_W-1:0] cnt;

    assign rep_hit[j] = db[j] && (cnt == RP_W'(REPEAT_DELAY));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (!db[j]) begin
        cnt <= '0;
      end else if (rep_hit[j]) begin
        cnt <= RP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
        cnt <= cnt + RP_W'(1);
      end
    end
  end

  // Press/repeat pulses, then priority-resolved events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_prev   <= '0;
      pls       <= '0;
      ev_center <= 1'b0;
      ev_swap   <= 1'b0;
      ev_up     <= 1'b0;
      ev_dn     <= 1'b0;
    end else begin
      db_prev   <= db;
      pls       <= (db & ~db_prev) | {3'b000, rep_hit};
      ev_center <= pls[B_CT];
      ev_swap   <= ~pls[B_CT] & (pls[B_LT] | pls[B_RT]);
      ev_up     <= ~(pls[B_CT] | pls[B_LT] | pls[B_RT]) & pls[B_UP] & ~pls[B_DN];
      ev_dn     <= ~(pls[B_CT] | pls[B_LT] | pls[B_RT]) & pls[B_DN] & ~pls[B_UP];
    end
  end

  state_t     state, state_nxt;
  logic [4:0] hrs_q, hrs_nxt;
  logic [5:0] min_q, min_nxt;
  logic       load_q, run_q, edit_q, pm_q, pm_nxt;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SET_MIN;
      hrs_q  <= '0;
      min_q  <= '0;
      load_q <= 1'b0;
      run_q  <= 1'b0;
      edit_q <= 1'b0;
      pm_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      hrs_q  <= hrs_nxt;
      min_q  <= min_nxt;
      load_q <= (state_nxt == COMMIT);
      run_q  <= (state_nxt == RUN);
      edit_q <= (state_nxt == SET_HR);
      pm_q   <= pm_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hrs_nxt   = hrs_q;
    min_nxt   = min_q;
    pm_nxt    = (state == RUN) ? (bus.cur_hrs >= 5'd12) : (hrs_q >= 5'd12);
    case (state)
      RUN: begin
        if (ev_center) begin
          hrs_nxt   = bus.cur_hrs;
          min_nxt   = bus.cur_min;
          state_nxt = SET_MIN;
        end
      end
      SET_MIN: begin
        if (ev_center)    state_nxt = COMMIT;
        else if (ev_swap) state_nxt = SET_HR;
        else if (ev_up)   min_nxt = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        else if (ev_dn)   min_nxt = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      end
      SET_HR: begin
        if (ev_center)    state_nxt = COMMIT;
        else if (ev_swap) state_nxt = SET_MIN;
        else if (ev_up)   hrs_nxt = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
        else if (ev_dn)   hrs_nxt = (hrs_q == 5'd0) ? 5'd23 : hrs_q - 5'd1;
      end
      COMMIT:  state_nxt = RUN;
      default: state_nxt = SET_MIN;
    endcase
  end

  assign bus.load           = load_q;
  assign bus.load_hrs       = hrs_q;
  assign bus.load_min       = min_q;
  assign bus.run_en         = run_q;
  assign bus.edit_field     = edit_q;
  assign bus.clock_mode_led = run_q;
  assign bus.pm_led         = pm_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short debounce/repeat timing.
// Button mask order is {center, left, right, up, down}.
module tb_clock_set_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;
  int   load_seen = 0;
  int   load_base;

  always #5 clk = ~clk;

  clock_set_controller_if bus ();

  clock_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(negedge clk) if (bus.load === 1'b1) load_seen <= load_seen + 1;

  typedef struct {
    logic [4:0] mask;
    int         presses;
    logic [4:0] cur_h;
    logic [5:0] cur_m;
    logic [4:0] e_hrs;
    logic [5:0] e_min;
    logic       e_run;
    logic       e_edit;
    logic       e_pm;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_btn(input logic [4:0] m);
    bus.center = m[4];
    bus.left   = m[3];
    bus.right  = m[2];
    bus.up     = m[1];
    bus.down   = m[0];
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    @(negedge clk);
    set_btn(m);
    repeat (hold) @(negedge clk);
    set_btn(5'b00000);
    repeat (14) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] h, input logic [5:0] mi,
                               input logic run, input logic edit, input logic pm);
    check({tag, ".load_hrs"}, 32'(bus.load_hrs), 32'(h));
    check({tag, ".load_min"}, 32'(bus.load_min), 32'(mi));
    check({tag, ".run_en"}, 32'(bus.run_en), 32'(run));
    check({tag, ".clock_mode_led"}, 32'(bus.clock_mode_led), 32'(run));
    check({tag, ".edit_field"}, 32'(bus.edit_field), 32'(edit));
    check({tag, ".pm_led"}, 32'(bus.pm_led), 32'(pm));
    check({tag, ".load"}, 32'(bus.load), 32'd0);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.cur_hrs = tbl[i].cur_h;
      bus.cur_min = tbl[i].cur_m;
      for (int p = 0; p < tbl[i].presses; p++) press(tbl[i].mask, 6);
      check_outputs($sformatf("row%0d", i), tbl[i].e_hrs, tbl[i].e_min,
                    tbl[i].e_run, tbl[i].e_edit, tbl[i].e_pm);
    end
  endtask

  initial begin
    //          mask      n  cur_h cur_m hrs min run edit pm
    tbl[0]  = '{5'b00001, 1,  0,  0,  0,  0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{5'b00001, 1,  0,  0,  0, 59, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{5'b00010, 1,  0,  0,  0,  0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{5'b00100, 1,  0,  0,  0,  0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{5'b00001, 1,  0,  0, 23,  0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{5'b00010, 1,  0,  0,  0,  0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{5'b00010, 7,  0,  0, 13,  0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{5'b01000, 1,  0,  0, 13,  0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{5'b00001, 15, 0,  0, 13, 45, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{5'b00010, 1,  9, 30, 13, 45, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{5'b01000, 1,  9, 30, 13, 45, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{5'b10000, 1,  9, 30,  9, 30, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{5'b00011, 1,  9, 30,  9, 30, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    set_btn(5'b00000);
    bus.cur_hrs = 5'd0;
    bus.cur_min = 6'd0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Short glitch: 3 cycles never passes debounce
    press(5'b00010, 3);
    check("glitch.load_min", 32'(bus.load_min), 32'd0);

    // Press latency: raw first sampled at edge k, update after edge k+8
    @(negedge clk);
    bus.up = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("lat.before", 32'(bus.load_min), 32'd0);
    @(posedge clk);
    #1 check("lat.after", 32'(bus.load_min), 32'd1);
    @(negedge clk);
    bus.up = 1'b0;
    repeat (14) @(negedge clk);

    apply_rows(0, 5);

    // Auto-repeat in SET_HR from 0: press + repeats at +20..+40
    @(negedge clk);
    bus.up = 1'b1;
    repeat (20) @(negedge clk);
    check("rep.m20", 32'(bus.load_hrs), 32'd1);
    repeat (15) @(negedge clk);
    check("rep.m35", 32'(bus.load_hrs), 32'd3);
    repeat (8) @(negedge clk);
    bus.up = 1'b0;
    repeat (14) @(negedge clk);
    check("rep.final", 32'(bus.load_hrs), 32'd6);
    repeat (30) @(negedge clk);
    check("rep.hold", 32'(bus.load_hrs), 32'd6);
    check("rep.min", 32'(bus.load_min), 32'd0);

    apply_rows(6, 8);

    // Commit 13:45
    bus.cur_hrs = 5'd13;
    bus.cur_min = 6'd45;
    @(negedge clk);
    load_base = load_seen;
    bus.center = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("commit.pre_load", 32'(bus.load), 32'd0);
    @(posedge clk);
    #1 check("commit.load", 32'(bus.load), 32'd1);
    check("commit.hrs", 32'(bus.load_hrs), 32'd13);
    check("commit.min", 32'(bus.load_min), 32'd45);
    check("commit.run_low", 32'(bus.run_en), 32'd0);
    @(posedge clk);
    #1 check("commit.load_drop", 32'(bus.load), 32'd0);
    check("commit.run_en", 32'(bus.run_en), 32'd1);
    @(negedge clk);
    bus.center = 1'b0;
    repeat (14) @(negedge clk);
    check("commit.pulses", 32'(load_seen - load_base), 32'd1);
    check_outputs("commit.run", 5'd13, 6'd45, 1'b1, 1'b0, 1'b1);

    apply_rows(9, 12);

    // center+up together -> COMMIT only; reset during COMMIT
    @(negedge clk);
    load_base = load_seen;
    bus.center = 1'b1;
    bus.up = 1'b1;
    repeat (9) @(posedge clk);
    #1 check("prio.load", 32'(bus.load), 32'd1);
    check("prio.min", 32'(bus.load_min), 32'd30);
    reset = 1'b1;
    #1 check_outputs("rst_commit", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.center = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst.no_load", 32'(load_seen - load_base), 32'd0);

    // up held through reset is a fresh press
    repeat (6) @(negedge clk);
    bus.up = 1'b0;
    repeat (14) @(negedge clk);
    check_outputs("held", 5'd0, 6'd1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Front-end controller for the 12/24-hour digital clock. It debounces the five push buttons and generates press and auto-repeat events, then runs the run/set-minutes/set-hours mode FSM. It drives a load strobe with preset hours and minutes, plus a run enable, into the timekeeping datapath. Hours are held internally in 24-hour form (0-23); 12-hour display conversion is downstream.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz)
REPEAT_DELAY, 50_000_000, cycles up/down must be held after the press event before the first auto-repeat event
REPEAT_PERIOD, 25_000_000, cycles between auto-repeat events while up/down stays held (4 Hz)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
center  input  1  raw button: enter/commit set mode
left  input  1  raw button: swap edit field
right  input  1  raw button: swap edit field
up  input  1  raw button: increment field
down  input  1  raw button: decrement field
cur_hrs  input  5  live hours from timekeeper, 0-23
cur_min  input  6  live minutes from timekeeper, 0-59
load  output  1  one-cycle strobe: timekeeper loads load_hrs/load_min and clears seconds
load_hrs  output  5  preset hours (edit register)
load_min  output  6  preset minutes (edit register)
run_en  output  1  1 = timekeeper counts seconds
edit_field  output  1  0 = minutes selected, 1 = hours selected
clock_mode_led  output  1  equals run_en
pm_led  output  1  1 when displayed hour >= 12

Behaviour:
- Reset values (asynchronous, all registered): state=SET_MIN, load_hrs=0, load_min=0, load=0, run_en=0, edit_field=0, clock_mode_led=0, pm_led=0. Synchronizers, debounced levels, and debounce/repeat counters are all 0.
- Button input path, per button:
  - 2-flop synchronizer.
  - Debounced level toggles once the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreement in between clears the counter.
- Press event: one-cycle pulse on the 0->1 edge of a debounced level.
  - Latency: raw high first sampled at edge k; pulse is visible in cycle k+DEBOUNCE_CYCLES+3.
  - Release produces no event.
- Auto-repeat (up/down only):
  - First repeat pulse REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles while the debounced level stays 1.
  - Counter clears on release.
  - center/left/right never repeat.
- Event priority when several events arrive in one cycle: center > left/right > up/down.
  - Only the highest-priority event is acted on; the others are dropped.
  - up and down together: both dropped.
- FSM:
  - RUN: run_en=1, edit_field=0. On center: copy cur_hrs/cur_min into the edit registers, go to SET_MIN, run_en=0 next cycle. All other events ignored.
  - SET_MIN: edit_field=0.
    - up: load_min = (load_min==59) ? 0 : +1, with no carry into hours.
    - down: 0 -> 59, no borrow from hours.
    - left/right: go to SET_HR.
    - center: go to COMMIT.
  - SET_HR: edit_field=1.
    - up: 23 -> 0.
    - down: 0 -> 23.
    - left/right: go to SET_MIN.
    - center: go to COMMIT.
  - COMMIT: exactly one cycle. load=1 with current edit values, then RUN. run_en rises in the cycle after load.
- Edit-register updates appear in the cycle after the event pulse. load_hrs/load_min stay stable outside events.
- pm_led: (cur_hrs>=12) in RUN, (load_hrs>=12) otherwise; registered, one-cycle lag.
- Reset mid-operation: the block returns to its reset state immediately and no load is issued. A button still held through reset is accepted as a new press after debounce.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.)
1. Out of reset, press up for 3 cycles only -> no event. Press up for 10 cycles -> one press pulse at edge k+7; load_min 0->1.
2. SET_MIN with load_min=59, press up -> load_min=0, load_hrs unchanged. SET_HR with load_hrs=0, press down -> load_hrs=23.
3. Hold up for 40 cycles after the press pulse in SET_HR from 0 -> press pulse plus repeats at +20, +25, +30, +35, +40 -> load_hrs=6. Release -> no further change.
4. Set 13:45 via right/up/down, then press center -> exactly one load pulse with load_hrs=13, load_min=45; run_en=1 the next cycle; pm_led=1.
5. In RUN with cur_hrs=9, cur_min=30: press up -> ignored. Press center -> load_hrs=9, load_min=30, state SET_MIN, run_en=0, pm_led=0.
6. center and up debounced in the same cycle in SET_MIN -> COMMIT only, minutes unchanged. Assert reset during COMMIT -> load=0, all outputs at reset values.
